dt_bin_pack: RTL and testbench

- Reverse-direction companion to the distance-transform engine.
- Reads the 128x128 8-bit distance map from the result RAM in raster order and thresholds each pixel to one bit.
- Packs the bits into 16-bit words in the same layout as the binary source image and writes them to a 1024x16 image RAM.
- Used to rebuild or erode the binary image from a finished distance map. Optionally reports object-pixel count and maximum distance.

---
 rtl/dt_bin_pack.sv | 171 +++++++++++++++++
 tb/tb_dt_bin_pack.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dt_bin_pack.sv
// dt_bin_pack: reads a 128x128 distance map from the result RAM in raster
// order, thresholds each pixel (res_di > thr) and packs the bits into 16-bit
// words written to a 1024x16 binary image RAM. Pixel col[3:0] selects the bit
// position inside a word.
// Optional statistics (object-pixel count, maximum distance) are built only
// when the macro DTBP_STAT_EN is defined; otherwise both outputs are tied to 0.
module dt_bin_pack #(
  parameter int DIST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIST_W-1:0] thr,
  output logic              res_rd,
  output logic [13:0]       res_addr,
  input  logic [DIST_W-1:0] res_di,
  output logic              sti_wr,
  output logic [9:0]        sti_addr,
  output logic [15:0]       sti_do,
  output logic              done,
  output logic [14:0]       obj_cnt,
  output logic [DIST_W-1:0] max_dist
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [DIST_W-1:0] r_thr;
  logic              r_rd;
  logic [13:0]       r_addr;
  logic              r_drain;
  logic              r_done;

  // Pipeline: data for the address issued one cycle earlier
  logic              r_vld;
  logic [13:0]       r_daddr;

  logic [15:0]       r_shreg;
  logic              r_sti_wr;
  logic [9:0]        r_sti_addr;
  logic [15:0]       r_sti_do;

  logic              w_accept;
  logic              w_bit;
  logic [15:0]       w_shnext;

  // start only counts while the engine is parked
  assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_bit    = (res_di > r_thr);
  assign w_shnext = {w_bit, r_shreg[15:1]};

  // Control FSM: address generation, drain timing and the done flag
  // NOTE: reset sits in the sensitivity list because it is asynchronous; all
  // state updates use non-blocking assignments so every register samples
  // pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_thr   <= '0;
      r_rd    <= 1'b0;
      r_addr  <= '0;
      r_drain <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_state <= S_RUN;
            r_thr   <= thr;
            r_rd    <= 1'b1;
            r_addr  <= '0;
            r_done  <= 1'b0;
          end
        end
        S_RUN: begin
          if (r_addr == 14'h3FFF) begin
            r_state <= S_DRAIN;
            r_rd    <= 1'b0;
            r_drain <= 1'b0;
          end else begin
            r_addr <= r_addr + 14'd1;
          end
        end
        S_DRAIN: begin
          if (r_drain) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end else begin
            r_drain <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Valid bit and delayed address follow the one-cycle RAM read latency
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_vld   <= 1'b0;
      r_daddr <= '0;
    end else begin
      r_vld   <= r_rd;
      r_daddr <= r_addr;
    end
  end

  // Shift pixel bits in at bit 15; emit a word after column LSBs reach 15
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg    <= '0;
      r_sti_wr   <= 1'b0;
      r_sti_addr <= '0;
      r_sti_do   <= '0;
    end else begin
      r_sti_wr <= 1'b0;
      if (w_accept) begin
        r_shreg <= '0;
      end else if (r_vld) begin
        r_shreg <= w_shnext;
        if (r_daddr[3:0] == 4'hF) begin
          r_sti_wr   <= 1'b1;
          r_sti_addr <= r_daddr[13:4];
          r_sti_do   <= w_shnext;
        end
      end
    end
  end

`ifdef DTBP_STAT_EN
  logic [14:0]       r_obj_cnt;
  logic [DIST_W-1:0] r_max_dist;

  // Per-pass statistics over every valid pixel; cleared on an accepted start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_obj_cnt  <= '0;
      r_max_dist <= '0;
    end else if (w_accept) begin
      r_obj_cnt  <= '0;
      r_max_dist <= '0;
    end else if (r_vld) begin
      if (w_bit) begin
        r_obj_cnt <= r_obj_cnt + 15'd1;
      end
      if (res_di > r_max_dist) begin
        r_max_dist <= res_di;
      end
    end
  end

  assign obj_cnt  = r_obj_cnt;
  assign max_dist = r_max_dist;
`else
  assign obj_cnt  = '0;
  assign max_dist = '0;
`endif

  assign res_rd   = r_rd;
  assign res_addr = r_addr;
  assign sti_wr   = r_sti_wr;
  assign sti_addr = r_sti_addr;
  assign sti_do   = r_sti_do;
  assign done     = r_done;

endmodule

// File: tb/tb_dt_bin_pack.sv
// Directed testbench for dt_bin_pack: a result-RAM model feeds the DUT, a
// negedge monitor captures image writes and timing relative to the start edge.
// Cycle n of a pass is the clock period that ends at the n-th edge after the
// edge that sampled start.
module tb_dt_bin_pack;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  thr = '0;
  logic [7:0]  res_di = '0;
  logic        res_rd;
  logic [13:0] res_addr;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;
  logic        done;
  logic [14:0] obj_cnt;
  logic [7:0]  max_dist;

  dt_bin_pack #(.DIST_W(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .thr      (thr),
    .res_rd   (res_rd),
    .res_addr (res_addr),
    .res_di   (res_di),
    .sti_wr   (sti_wr),
    .sti_addr (sti_addr),
    .sti_do   (sti_do),
    .done     (done),
    .obj_cnt  (obj_cnt),
    .max_dist (max_dist)
  );

  always #5 clk = ~clk;

  logic [7:0]  rmem [16384];
  logic [15:0] img [1024];
  bit          wrote [1024];

  int cyc = 0;
  int t0 = -100;
  int wr_cnt = 0, dup_cnt = 0;
  int first_cyc = -1, first_addr = -1, last_cyc = -1, last_addr = -1;
  int done_cyc = -1;
  int errors = 0, checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Result RAM model: one-cycle read latency
  always @(posedge clk) if (res_rd) res_di <= rmem[res_addr];

  // Write / done monitor; counters restart on the first cycle of each pass
  always @(negedge clk) begin
    if (cyc == t0 + 1) begin
      wr_cnt = 0; dup_cnt = 0;
      first_cyc = -1; first_addr = -1; last_cyc = -1; last_addr = -1;
      done_cyc = -1;
      for (int w = 0; w < 1024; w++) begin
        img[w] = 16'hDEAD;
        wrote[w] = 1'b0;
      end
    end
    if (sti_wr) begin
      if (first_cyc < 0) begin
        first_cyc = cyc - t0;
        first_addr = int'(sti_addr);
      end
      last_cyc = cyc - t0;
      last_addr = int'(sti_addr);
      if (wrote[sti_addr]) dup_cnt++;
      wrote[sti_addr] = 1'b1;
      img[sti_addr] = sti_do;
      wr_cnt++;
    end
    if (done && done_cyc < 0) done_cyc = cyc - t0;
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic fill_map(input logic [7:0] v);
    for (int i = 0; i < 16384; i++) rmem[i] = v;
  endtask

  task automatic step_to(input int rel);
    for (int i = 0; i < 20000 && (cyc - t0) < rel; i++) step();
  endtask

  task automatic check_outputs_zero(input string name);
    logic [66:0] all_out;
    all_out = {res_rd, res_addr, sti_wr, sti_addr, sti_do, done, obj_cnt, max_dist};
    checks++;
    if (all_out !== '0) begin
      errors++;
      $display("FAIL %s: outputs=%h required all zero", name, all_out);
    end
  endtask

  // Start a pass with threshold t; done must drop and reading begin at addr 0
  task automatic launch(input logic [7:0] t);
    thr = t;
    start = 1'b1;
    t0 = cyc;
    step();
    start = 1'b0;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL launch_done_drop: done=%b required 0", done);
    end
    checks++;
    if ({res_rd, res_addr} !== {1'b1, 14'd0}) begin
      errors++;
      $display("FAIL launch_first_read: rd=%b addr=%0d required rd=1 addr=0", res_rd, res_addr);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 17000; i++) begin
      if (done === 1'b1) break;
      step();
    end
    repeat (20) step();
  endtask

  // Timing, write count and image contents of a completed pass
  task automatic verify_pass(input string name, input logic [15:0] fill,
                             input int sp_addr, input logic [15:0] sp_val,
                             input int e_obj, input int e_max);
    int bad;
    int bad_addr;
    logic [15:0] exp_w;
    int exp_obj;
    int exp_max;
`ifdef DTBP_STAT_EN
    exp_obj = e_obj;
    exp_max = e_max;
`else
    exp_obj = 0;
    exp_max = 0;
`endif
    checks++;
    if (done_cyc !== 16387) begin
      errors++;
      $display("FAIL %s_done_cycle: got %0d required 16387", name, done_cyc);
    end
    checks++;
    if (wr_cnt !== 1024 || dup_cnt !== 0) begin
      errors++;
      $display("FAIL %s_write_count: writes=%0d dups=%0d required 1024/0", name, wr_cnt, dup_cnt);
    end
    checks++;
    if (first_cyc !== 18 || first_addr !== 0) begin
      errors++;
      $display("FAIL %s_first_write: cycle=%0d addr=%0d required 18/0", name, first_cyc, first_addr);
    end
    checks++;
    if (last_cyc !== 16386 || last_addr !== 1023) begin
      errors++;
      $display("FAIL %s_last_write: cycle=%0d addr=%0d required 16386/1023", name, last_cyc, last_addr);
    end
    bad = 0;
    bad_addr = -1;
    for (int w = 0; w < 1024; w++) begin
      exp_w = (w == sp_addr) ? sp_val : fill;
      if (img[w] !== exp_w) begin
        if (bad == 0) bad_addr = w;
        bad++;
      end
    end
    checks++;
    if (bad != 0) begin
      errors++;
      exp_w = (bad_addr == sp_addr) ? sp_val : fill;
      $display("FAIL %s_image: %0d bad words, first at %0d got %h required %h",
               name, bad, bad_addr, img[bad_addr], exp_w);
    end
    checks++;
    if (int'(obj_cnt) !== exp_obj || int'(max_dist) !== exp_max) begin
      errors++;
      $display("FAIL %s_stats: obj_cnt=%0d max_dist=%0d required %0d/%0d",
               name, obj_cnt, max_dist, exp_obj, exp_max);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) step();
    check_outputs_zero("reset_state");
    reset = 1'b0;
    step();
    check_outputs_zero("idle_after_reset");
  endtask

  // Only pixel (1,1)=1 with thr=0: word 8 bit 1 set
  task automatic test_single_pixel();
    fill_map(8'd0);
    rmem[{7'd1, 7'd1}] = 8'd1;
    launch(8'd0);
    wait_done();
    verify_pass("single_pixel", 16'h0000, 8, 16'h0002, 1, 1);
  endtask

  // Strict compare at thr=2, plus a start pulse during RUN that must be ignored
  task automatic test_strict_and_ignore_start();
    fill_map(8'd0);
    rmem[{7'd64, 7'd127}] = 8'd5;
    rmem[{7'd64, 7'd112}] = 8'd2;
    launch(8'd2);
    step_to(3000);
    thr = 8'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    checks++;
    if ({done, res_rd} !== 2'b01 || res_addr !== 14'd3000) begin
      errors++;
      $display("FAIL run_start_ignored: done=%b rd=%b addr=%0d required 0/1/3000",
               done, res_rd, res_addr);
    end
    wait_done();
    verify_pass("strict_cmp", 16'h0000, 519, 16'h8000, 1, 5);
  endtask

  // Reset at cycle 5000 of a pass: everything clears and writes stop
  task automatic test_reset_mid_pass();
    int snap;
    fill_map(8'd3);
    launch(8'd3);
    step_to(5000);
    reset = 1'b1;
    #1;
    check_outputs_zero("mid_pass_reset");
    snap = wr_cnt;
    checks++;
    if (snap !== 312) begin
      errors++;
      $display("FAIL partial_writes: got %0d required 312", snap);
    end
    repeat (3) step();
    reset = 1'b0;
    repeat (50) step();
    checks++;
    if (wr_cnt !== snap || done !== 1'b0 || res_rd !== 1'b0) begin
      errors++;
      $display("FAIL no_writes_after_reset: writes=%0d done=%b rd=%b required %0d/0/0",
               wr_cnt, done, res_rd, snap);
    end
  endtask

  // Clean pass after the aborted one: all 3s at thr=3 give an empty image
  task automatic test_full_thr_equal();
    launch(8'd3);
    wait_done();
    verify_pass("all3_thr3", 16'h0000, 0, 16'h0000, 0, 3);
  endtask

  // New start from DONE latches thr=2: every pixel becomes object
  task automatic test_back_to_back();
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL done_before_restart: done=%b required 1", done);
    end
    launch(8'd2);
    wait_done();
    verify_pass("all3_thr2", 16'hFFFF, 0, 16'hFFFF, 16384, 3);
  endtask

  initial begin
    test_reset();
    test_single_pixel();
    test_strict_and_ignore_start();
    test_reset_mid_pass();
    test_full_thr_equal();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
